// File: rtl/udp_payload_gen.sv
// Parametrised UDP payload source for the 32-bit send_top application interface.
// Generates packets of runtime length in incrementing, LFSR or fixed patterns with valid/ready.
module udp_payload_gen #(
  parameter int unsigned MAX_LEN_BYTES = 1024,
  parameter logic [31:0] LFSR_SEED     = 32'hFFFFFFFF,
  parameter int unsigned GAP_W         = 16
) (
  input  logic             clk_32,
  input  logic             reset_32,
  input  logic             enable,
  input  logic [1:0]       cfg_mode,
  input  logic [15:0]      cfg_len_bytes,
  input  logic [15:0]      cfg_pkt_count,
  input  logic [GAP_W-1:0] cfg_gap,
  input  logic [31:0]      cfg_pattern,
  input  logic             cfg_insert_error,
  output logic [31:0]      udp_from_app_data,
  output logic [3:0]       udp_from_app_keep,
  output logic             udp_from_app_valid,
  output logic             udp_from_app_last,
  input  logic             udp_to_app_ready,
  output logic [15:0]      data_from_app_length,
  output logic             busy,
  output logic             done,
  output logic [31:0]      pkt_sent,
  output logic             gen_active_flash
);

  localparam logic [15:0] MaxLen = 16'(MAX_LEN_BYTES);

  typedef enum logic [2:0] {StIdle, StLoad, StSend, StGap, StHold} state_e;

  state_e           state_q, state_d;
  logic [1:0]       tail_q, tail_d, mode_q, mode_d;
  logic [15:0]      words_q, words_d, count_q, count_d, k_q, k_d, seq_q, seq_d;
  logic [31:0]      pattern_q, pattern_d, lfsr_q, lfsr_d;
  logic             err_q, err_d;
  logic [GAP_W-1:0] gap_len_q, gap_len_d, gap_cnt_q, gap_cnt_d;
  logic [31:0]      data_q, data_d, pkt_sent_q, pkt_sent_d;
  logic [3:0]       keep_q, keep_d;
  logic             valid_q, valid_d, last_q, last_d, busy_q, done_q, done_d;
  logic             flash_q, flash_d;
  logic [15:0]      length_q, length_d;

  logic [15:0] len_clamp, words_clamp;
  logic [31:0] lfsr_step;

  assign len_clamp   = (cfg_len_bytes == 16'd0) ? 16'd1 :
                       (cfg_len_bytes > MaxLen) ? MaxLen : cfg_len_bytes;
  assign words_clamp = (len_clamp + 16'd3) >> 2;
  // Galois step: x^32 + x^22 + x^2 + x + 1, msb feeds back into bit 0.
  assign lfsr_step   = {lfsr_q[30:0], 1'b0} ^ (lfsr_q[31] ? 32'h0040_0007 : 32'h0);

  // Next beat to present: beat 0 of a new packet in LOAD, beat k+1 otherwise.
  logic [1:0]  b_mode, b_tail;
  logic [31:0] b_pat, b_lfsr, b_raw, b_data;
  logic        b_err, b_last;
  logic [15:0] b_words, b_k;
  logic [3:0]  b_keep;

  always_comb begin
    b_mode  = mode_q;
    b_tail  = tail_q;
    b_pat   = pattern_q;
    b_err   = err_q;
    b_words = words_q;
    b_k     = k_q + 16'd1;
    b_lfsr  = lfsr_step;
    if (state_q == StLoad) begin
      b_mode  = cfg_mode;
      b_tail  = len_clamp[1:0];
      b_pat   = cfg_pattern;
      b_err   = cfg_insert_error;
      b_words = words_clamp;
      b_k     = 16'd0;
      b_lfsr  = lfsr_q;
    end
    b_last = (b_k == b_words - 16'd1);
    b_keep = 4'hF;
    if (b_last) begin
      case (b_tail)
        2'd1:    b_keep = 4'b1000;
        2'd2:    b_keep = 4'b1100;
        2'd3:    b_keep = 4'b1110;
        default: b_keep = 4'b1111;
      endcase
    end
    case (b_mode)
      2'd1:    b_raw = b_lfsr;
      2'd2:    b_raw = b_pat;
      default: b_raw = {seq_q, b_k};
    endcase
    b_data = b_raw & {{8{b_keep[3]}}, {8{b_keep[2]}}, {8{b_keep[1]}}, {8{b_keep[0]}}};
    if (b_last && b_err) b_data[24] = ~b_data[24];
  end

  always_comb begin
    logic exit_eval;
    exit_eval  = 1'b0;
    state_d    = state_q;
    tail_d     = tail_q;
    mode_d     = mode_q;
    words_d    = words_q;
    count_d    = count_q;
    k_d        = k_q;
    seq_d      = seq_q;
    pattern_d  = pattern_q;
    lfsr_d     = lfsr_q;
    err_d      = err_q;
    gap_len_d  = gap_len_q;
    gap_cnt_d  = gap_cnt_q;
    data_d     = data_q;
    keep_d     = keep_q;
    valid_d    = valid_q;
    last_d     = last_q;
    length_d   = length_q;
    done_d     = 1'b0;
    pkt_sent_d = pkt_sent_q;
    flash_d    = flash_q;
    case (state_q)
      StIdle: begin
        if (enable) begin
          state_d = StLoad;
          seq_d   = 16'd0;
          lfsr_d  = LFSR_SEED;
        end
      end
      StLoad: begin
        tail_d    = len_clamp[1:0];
        words_d   = words_clamp;
        mode_d    = cfg_mode;
        pattern_d = cfg_pattern;
        err_d     = cfg_insert_error;
        gap_len_d = cfg_gap;
        count_d   = cfg_pkt_count;
        length_d  = len_clamp;
        k_d       = 16'd0;
        valid_d   = 1'b1;
        data_d    = b_data;
        keep_d    = b_keep;
        last_d    = b_last;
        state_d   = StSend;
      end
      StSend: begin
        if (valid_q && udp_to_app_ready) begin
          if (mode_q == 2'd1) lfsr_d = lfsr_step;
          if (last_q) begin
            pkt_sent_d = pkt_sent_q + 32'd1;
            flash_d    = ~flash_q;
            seq_d      = seq_q + 16'd1;
            valid_d    = 1'b0;
            data_d     = 32'd0;
            keep_d     = 4'd0;
            last_d     = 1'b0;
            if (gap_len_q != '0) begin
              state_d   = StGap;
              gap_cnt_d = gap_len_q;
            end else begin
              exit_eval = 1'b1;
            end
          end else begin
            k_d    = k_q + 16'd1;
            data_d = b_data;
            keep_d = b_keep;
            last_d = b_last;
          end
        end
      end
      StGap: begin
        if (gap_cnt_q == GAP_W'(1)) exit_eval = 1'b1;
        else gap_cnt_d = gap_cnt_q - GAP_W'(1);
      end
      StHold: begin
        if (!enable) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (exit_eval) begin
      if (count_q != 16'd0 && seq_d == count_q) begin
        done_d  = 1'b1;
        state_d = StHold;
      end else if (enable) begin
        state_d = StLoad;
      end else begin
        state_d = StIdle;
      end
    end
  end

  always_ff @(posedge clk_32 or posedge reset_32) begin
    if (reset_32) begin
      state_q    <= StIdle;
      tail_q     <= 2'd0;
      mode_q     <= 2'd0;
      words_q    <= 16'd0;
      count_q    <= 16'd0;
      k_q        <= 16'd0;
      seq_q      <= 16'd0;
      pattern_q  <= 32'd0;
      lfsr_q     <= LFSR_SEED;
      err_q      <= 1'b0;
      gap_len_q  <= '0;
      gap_cnt_q  <= '0;
      data_q     <= 32'd0;
      keep_q     <= 4'd0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      length_q   <= 16'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pkt_sent_q <= 32'd0;
      flash_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      tail_q     <= tail_d;
      mode_q     <= mode_d;
      words_q    <= words_d;
      count_q    <= count_d;
      k_q        <= k_d;
      seq_q      <= seq_d;
      pattern_q  <= pattern_d;
      lfsr_q     <= lfsr_d;
      err_q      <= err_d;
      gap_len_q  <= gap_len_d;
      gap_cnt_q  <= gap_cnt_d;
      data_q     <= data_d;
      keep_q     <= keep_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      length_q   <= length_d;
      busy_q     <= (state_d != StIdle);
      done_q     <= done_d;
      pkt_sent_q <= pkt_sent_d;
      flash_q    <= flash_d;
    end
  end

  assign udp_from_app_data    = data_q;
  assign udp_from_app_keep    = keep_q;
  assign udp_from_app_valid   = valid_q;
  assign udp_from_app_last    = last_q;
  assign data_from_app_length = length_q;
  assign busy                 = busy_q;
  assign done                 = done_q;
  assign pkt_sent             = pkt_sent_q;
  assign gen_active_flash     = flash_q;

endmodule

// File: tb/tb_udp_payload_gen.sv
// Scoreboard bench for udp_payload_gen: a reference model queues expected beats,
// a negedge monitor pops and compares them on every handshake.
module tb_udp_payload_gen;

  localparam int unsigned MaxLen = 1024;
  localparam logic [31:0] Seed   = 32'hFFFFFFFF;

  logic        clk_32, reset_32, enable, cfg_insert_error, ready;
  logic [1:0]  cfg_mode;
  logic [15:0] cfg_len_bytes, cfg_pkt_count, cfg_gap, length;
  logic [31:0] cfg_pattern, data, pkt_sent;
  logic [3:0]  keep;
  logic        valid, last, busy, done, flash;

  udp_payload_gen #(
    .MAX_LEN_BYTES(MaxLen),
    .LFSR_SEED    (Seed),
    .GAP_W        (16)
  ) dut (
    .clk_32              (clk_32),
    .reset_32            (reset_32),
    .enable              (enable),
    .cfg_mode            (cfg_mode),
    .cfg_len_bytes       (cfg_len_bytes),
    .cfg_pkt_count       (cfg_pkt_count),
    .cfg_gap             (cfg_gap),
    .cfg_pattern         (cfg_pattern),
    .cfg_insert_error    (cfg_insert_error),
    .udp_from_app_data   (data),
    .udp_from_app_keep   (keep),
    .udp_from_app_valid  (valid),
    .udp_from_app_last   (last),
    .udp_to_app_ready    (ready),
    .data_from_app_length(length),
    .busy                (busy),
    .done                (done),
    .pkt_sent            (pkt_sent),
    .gen_active_flash    (flash)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic [15:0] len;
  } beat_t;

  beat_t       exp_q[$];
  int          gap_q[$];
  int          tests = 0, fails = 0;
  int          done_cnt = 0, flash_tog = 0, hs_cnt = 0, low_cnt = 0;
  int          exp_pkt_sent = 0;
  bit          seen_last = 0, rand_ready = 0;
  logic [31:0] m_lfsr;
  beat_t       prev_beat;
  logic        prev_valid = 0, prev_ready = 0, prev_flash = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  initial begin
    clk_32 = 0;
    forever #5 clk_32 = ~clk_32;
  end

  initial begin
    ready = 1;
    forever begin
      @(posedge clk_32);
      #1;
      ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  // Reference model: appends the expected beats of one packet.
  task automatic push_pkt(input logic [1:0] mode, input int n, input int len_raw,
                          input logic [31:0] pat, input bit err);
    int          l, w;
    logic [31:0] raw;
    logic [15:0] n16, k16;
    beat_t       b;
    l = (len_raw == 0) ? 1 : ((len_raw > int'(MaxLen)) ? int'(MaxLen) : len_raw);
    w = (l + 3) / 4;
    n16 = 16'(n);
    for (int k = 0; k < w; k++) begin
      k16 = 16'(k);
      b.last = (k == w - 1);
      b.keep = 4'hF;
      if (b.last) begin
        case (l % 4)
          1: b.keep = 4'b1000;
          2: b.keep = 4'b1100;
          3: b.keep = 4'b1110;
          default: b.keep = 4'b1111;
        endcase
      end
      if (mode == 2'd1) begin
        raw = m_lfsr;
        if (m_lfsr[31]) m_lfsr = (m_lfsr << 1) ^ 32'h0040_0007;
        else m_lfsr = m_lfsr << 1;
      end else if (mode == 2'd2) begin
        raw = pat;
      end else begin
        raw = {n16, k16};
      end
      b.data = 32'd0;
      for (int i = 0; i < 4; i++) if (b.keep[i]) b.data[i*8 +: 8] = raw[i*8 +: 8];
      if (b.last && err) b.data[24] = ~b.data[24];
      b.len = 16'(l);
      exp_q.push_back(b);
    end
  endtask

  always @(negedge clk_32) begin
    beat_t cur, e;
    cur = '{data: data, keep: keep, last: last, len: length};
    if (reset_32) begin
      prev_valid = 0;
      prev_ready = 0;
      prev_flash = 0;
      low_cnt    = 0;
      seen_last  = 0;
    end else begin
      if (done) done_cnt++;
      if (flash != prev_flash) flash_tog++;
      if (prev_valid && !prev_ready && valid) check("stall_hold", 64'(cur), 64'(prev_beat));
      if (valid) begin
        if (seen_last) begin
          gap_q.push_back(low_cnt);
          seen_last = 0;
        end
        low_cnt = 0;
      end else begin
        low_cnt++;
      end
      if (valid && ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          check("extra_beat", 64'(cur), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("beat", 64'(cur), 64'(e));
        end
        if (last) seen_last = 1;
      end
      prev_valid = valid;
      prev_ready = ready;
      prev_flash = flash;
      prev_beat  = cur;
    end
  end

  task automatic run(input logic [1:0] mode, input int len, input int count, input int gap,
                     input logic [31:0] pat, input bit err_first, input int exp_gap);
    int  d0;
    bit  seen;
    cfg_mode      = mode;
    cfg_len_bytes = 16'(len);
    cfg_pkt_count = 16'(count);
    cfg_gap       = 16'(gap);
    cfg_pattern   = pat;
    m_lfsr        = Seed;
    for (int p = 0; p < count; p++) push_pkt(mode, p, len, pat, err_first && (p == 0));
    gap_q.delete();
    @(negedge clk_32);
    seen_last = 0;
    flash_tog = 0;
    d0 = done_cnt;
    cfg_insert_error = err_first;
    enable = 1;
    if (err_first) begin
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk_32);
        seen = valid;
      end
      check("first_valid_seen", 64'(seen), 64'd1);
      cfg_insert_error = 0;
    end
    seen = 0;
    for (int i = 0; i < 20000 && !seen; i++) begin
      @(negedge clk_32);
      seen = (done_cnt != d0);
    end
    check("done_seen", 64'(seen), 64'd1);
    repeat (2) @(negedge clk_32);
    exp_pkt_sent += count;
    check("done_pulses", 64'(done_cnt - d0), 64'd1);
    check("busy_in_hold", 64'(busy), 64'd1);
    check("sb_empty", 64'(exp_q.size()), 64'd0);
    check("pkt_sent", 64'(pkt_sent), 64'(exp_pkt_sent));
    check("flash_toggles", 64'(flash_tog), 64'(count));
    check("gap_count", 64'(gap_q.size()), 64'(count - 1));
    foreach (gap_q[i]) check("gap_len", 64'(gap_q[i]), 64'(exp_gap));
    enable = 0;
    repeat (2) @(negedge clk_32);
    check("busy_after_off", 64'(busy), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    int  base;
    bit  seen;
    reset_32 = 1;
    enable = 0;
    cfg_mode = 0;
    cfg_len_bytes = 0;
    cfg_pkt_count = 0;
    cfg_gap = 0;
    cfg_pattern = 0;
    cfg_insert_error = 0;
    repeat (3) @(negedge clk_32);
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_outs", {data, keep, last, length, done, flash}, 64'd0);
    check("rst_pkt_sent", 64'(pkt_sent), 64'd0);
    reset_32 = 0;
    repeat (2) @(negedge clk_32);

    run(2'd0, 256, 1, 0, 32'h0, 0, 1);
    run(2'd0, 7, 1, 0, 32'h0, 0, 1);
    run(2'd0, 0, 1, 0, 32'h0, 0, 1);
    run(2'd0, 5000, 1, 0, 32'h0, 0, 1);
    run(2'd0, 64, 3, 10, 32'h0, 0, 11);
    rand_ready = 1;
    run(2'd1, 40, 3, 0, 32'h0, 0, 1);
    run(2'd3, 13, 2, 2, 32'h0, 0, 3);
    rand_ready = 0;
    run(2'd2, 8, 2, 0, 32'hA5A5A5A5, 1, 1);

    // Asynchronous reset in the middle of a 64-beat packet.
    cfg_mode = 2'd0;
    cfg_len_bytes = 16'd256;
    cfg_pkt_count = 16'd1;
    cfg_gap = 16'd0;
    m_lfsr = Seed;
    push_pkt(2'd0, 0, 256, 32'h0, 0);
    base = hs_cnt;
    enable = 1;
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk_32);
      seen = (hs_cnt >= base + 5);
    end
    check("reached_beat5", 64'(seen), 64'd1);
    #2 reset_32 = 1;
    #1;
    check("rst_mid_valid", 64'(valid), 64'd0);
    check("rst_mid_pkt_sent", 64'(pkt_sent), 64'd0);
    exp_q.delete();
    exp_pkt_sent = 0;
    enable = 0;
    repeat (2) @(negedge clk_32);
    reset_32 = 0;
    repeat (2) @(negedge clk_32);
    run(2'd0, 8, 1, 0, 32'h0, 0, 1);
    run(2'd1, 8, 1, 0, 32'h0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
